return_coin_dispenser: RTL and testbench
========================================

# return_coin_dispenser

Change-return engine for the vending machine; performs the reverse of coin-total accumulation. On a return request it captures the current balance and pays it out as a sequence of individual coins, largest denomination first. Each coin is transferred over a valid/ready handshake to the coin hopper. It reports the unpaid remainder and a completion pulse to the top-level vending FSM.

## Interface
- kTotalBits, 31, width of balance/remainder
- kNumCoins, 3, number of coin denominations (one-hot coin bus width)
- kCoinValue0, 100, value of coin index 0 (smallest)
- kCoinValue1, 500, value of coin index 1
- kCoinValue2, 1000, value of coin index 2 (largest)

- clk  in  1  system clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- i_trigger_return  in  1  start refund; sampled only in IDLE
- i_balance  in  kTotalBits  balance to refund, captured with trigger
- i_coin_ready  in  1  hopper accepts offered coin this cycle
- o_return_coin  out  kNumCoins  one-hot coin offered; 0 when not valid
- o_coin_valid  out  1  coin offer valid
- o_busy  out  1  refund in progress (any state but IDLE)
- o_done  out  1  one-cycle pulse at end of refund
- o_remaining  out  kTotalBits  balance not yet paid out
- o_coin_count  out  8  coins dispensed in current/last refund, saturating at 255

## Operation
- States: IDLE, SELECT, OFFER, DONE.
- IDLE: if i_trigger_return=1, remaining <= i_balance, coin_count <= 0, go SELECT; otherwise stay.
- SELECT: greedy choice of the largest index i with kCoinValue_i <= remaining; latch one-hot coin, go OFFER. If no coin fits (remaining < kCoinValue0, including 0), go DONE.
- OFFER: o_coin_valid=1, o_return_coin = latched one-hot. Both are held stable until handshake. Handshake = o_coin_valid & i_coin_ready at a rising edge. On handshake: remaining <= remaining - value, coin_count++ (saturating), go SELECT.
- DONE: o_done=1 for exactly this cycle, go IDLE. o_remaining holds the residue (< kCoinValue0) until the next trigger.
- i_trigger_return outside IDLE is ignored; i_balance is ignored except at the capture edge.
- Arithmetic: compare with coin values zero-extended to kTotalBits. Subtraction never underflows because selection guarantees value <= remaining. No wrap.
- i_coin_ready while not valid has no effect.

## Timing
- Reset (async assert, sync release not required): state=IDLE, o_return_coin=0, o_coin_valid=0, o_busy=0, o_done=0, o_remaining=0, o_coin_count=0. Outputs drop immediately on reset_n falling, including mid-OFFER; a coin offer in progress is abandoned.
- Trigger captured at edge T. SELECT during cycle T+1; first o_coin_valid during cycle T+2 (2-cycle latency).
- Handshake at edge H → SELECT in H+1 (valid low) → next offer valid in H+2. Maximum rate is 1 coin per 2 cycles.
- Zero/sub-minimum balance: trigger at T → SELECT T+1 → o_done high in cycle T+2, no coin offered.
- o_done asserts the cycle after the last SELECT. o_busy is low in the same cycle as o_done? No: o_busy=1 in SELECT/OFFER/DONE and drops the cycle after o_done.
- New trigger is accepted at the earliest on the first IDLE cycle after DONE.

## Test plan
- Balance 1600, ready tied high: coins 1000, 500, 100 on cycles T+2, T+4, T+6; o_done at T+8; o_remaining=0; o_coin_count=3.
- Balance 2700: sequence 1000, 1000, 500, 100, 100; o_coin_count=5; o_remaining=0.
- Backpressure: balance 500, ready low 3 cycles after valid: o_return_coin=3'b010 and valid held stable 3 cycles; single transfer on ready; remaining 0.
- Balance 250: coins 100, 100; o_done; o_remaining=50. Balance 0: o_done at T+2, o_coin_valid never high.
- Trigger with balance 9999 pulsed during an active 1600 refund: ignored, payout stays 1000/500/100.
- reset_n low during OFFER of 1000-coin: o_coin_valid, o_return_coin, o_busy go 0 without a clock edge. After release, state is IDLE and o_remaining=0.

Source files
------------

// File: rtl/return_coin_dispenser.sv
// Change-return engine: captures a balance on request and pays it out one
// coin at a time, largest denomination first, over a valid/ready handshake.
module return_coin_dispenser #(
   parameter int unsigned kTotalBits  = 31,
   parameter int unsigned kNumCoins   = 3,
   parameter int unsigned kCoinValue0 = 100,
   parameter int unsigned kCoinValue1 = 500,
   parameter int unsigned kCoinValue2 = 1000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_trigger_return,
   input  logic [kTotalBits-1:0] i_balance,
   input  logic                  i_coin_ready,
   output logic [kNumCoins-1:0]  o_return_coin,
   output logic                  o_coin_valid,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [kTotalBits-1:0] o_remaining,
   output logic [7:0]            o_coin_count
);

   typedef enum logic [1:0] {
      StIdle,
      StSelect,
      StOffer,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [kTotalBits-1:0] remaining_q, remaining_d;
   logic [7:0]            coin_count_q, coin_count_d;
   logic [kNumCoins-1:0]  coin_q, coin_d;

   logic [kNumCoins-1:0]  sel_coin;
   logic                  sel_found;
   logic [kTotalBits-1:0] offer_value;
   logic                  handshake;

   // Coin values zero-extended to the balance width; index order is ascending value.
   function automatic logic [kTotalBits-1:0] coin_value(input int unsigned idx);
      case (idx)
         0:       coin_value = kTotalBits'(kCoinValue0);
         1:       coin_value = kTotalBits'(kCoinValue1);
         default: coin_value = kTotalBits'(kCoinValue2);
      endcase
   endfunction

   // Greedy pick: the highest index whose value fits wins.
   always_comb begin
      sel_coin  = '0;
      sel_found = 1'b0;
      for (int unsigned i = 0; i < kNumCoins; i++) begin
         if (coin_value(i) <= remaining_q) begin
            sel_coin    = '0;
            sel_coin[i] = 1'b1;
            sel_found   = 1'b1;
         end
      end
   end

   // Value of the latched one-hot coin, subtracted on handshake.
   always_comb begin
      offer_value = '0;
      for (int unsigned i = 0; i < kNumCoins; i++) begin
         if (coin_q[i]) begin
            offer_value = offer_value | coin_value(i);
         end
      end
   end

   assign handshake = (state_q == StOffer) && i_coin_ready;

   // Next-state and datapath updates.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      coin_count_d = coin_count_q;
      coin_d       = coin_q;
      unique case (state_q)
         StIdle: begin
            if (i_trigger_return) begin
               remaining_d  = i_balance;
               coin_count_d = '0;
               state_d      = StSelect;
            end
         end
         StSelect: begin
            if (sel_found) begin
               coin_d  = sel_coin;
               state_d = StOffer;
            end else begin
               state_d = StDone;
            end
         end
         StOffer: begin
            if (handshake) begin
               // Selection guarantees offer_value <= remaining_q.
               remaining_d = remaining_q - offer_value;
               if (coin_count_q != 8'hFF) begin
                  coin_count_d = coin_count_q + 8'd1;
               end
               state_d = StSelect;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         remaining_q  <= '0;
         coin_count_q <= '0;
         coin_q       <= '0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         coin_count_q <= coin_count_d;
         coin_q       <= coin_d;
      end
   end

   // Outputs decode straight from state so reset clears them without a clock edge.
   always_comb begin
      o_coin_valid  = (state_q == StOffer);
      o_return_coin = o_coin_valid ? coin_q : '0;
      o_busy        = (state_q != StIdle);
      o_done        = (state_q == StDone);
      o_remaining   = remaining_q;
      o_coin_count  = coin_count_q;
   end

endmodule

// File: tb/tb_return_coin_dispenser.sv
// Directed bench for return_coin_dispenser with hand-computed expectations.
module tb_return_coin_dispenser;

   logic        clk;
   logic        reset_n;
   logic        i_trigger_return;
   logic [30:0] i_balance;
   logic        i_coin_ready;
   logic [2:0]  o_return_coin;
   logic        o_coin_valid;
   logic        o_busy;
   logic        o_done;
   logic [30:0] o_remaining;
   logic [7:0]  o_coin_count;

   int n_tests = 0;
   int n_fail  = 0;

   return_coin_dispenser dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_trigger_return (i_trigger_return),
      .i_balance        (i_balance),
      .i_coin_ready     (i_coin_ready),
      .o_return_coin    (o_return_coin),
      .o_coin_valid     (o_coin_valid),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_remaining      (o_remaining),
      .o_coin_count     (o_coin_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full refund with ready held high; seq holds one-hot coins, first coin in bits [2:0].
   task automatic refund(input string tag, input logic [30:0] bal, input int n,
                         input logic [23:0] seq, input logic [30:0] exp_rem,
                         input bit inject);
      i_coin_ready     = 1'b1;
      i_balance        = bal;
      i_trigger_return = 1'b1;
      step();
      i_trigger_return = 1'b0;
      i_balance        = 31'd0;
      check({tag, ".sel_valid"}, 32'(o_coin_valid), 32'd0);
      check({tag, ".sel_busy"}, 32'(o_busy), 32'd1);
      for (int k = 0; k < n; k++) begin
         step();
         check($sformatf("%s.valid%0d", tag, k), 32'(o_coin_valid), 32'd1);
         check($sformatf("%s.coin%0d", tag, k), 32'(o_return_coin), 32'(seq[3*k +: 3]));
         if (inject && k == 0) begin
            i_balance        = 31'd9999;
            i_trigger_return = 1'b1;
         end
         step();
         i_trigger_return = 1'b0;
         check($sformatf("%s.gap%0d", tag, k), 32'(o_coin_valid), 32'd0);
      end
      step();
      check({tag, ".done"}, 32'(o_done), 32'd1);
      check({tag, ".done_busy"}, 32'(o_busy), 32'd1);
      check({tag, ".rem"}, 32'(o_remaining), 32'(exp_rem));
      check({tag, ".count"}, 32'(o_coin_count), 32'(n));
      step();
      check({tag, ".done_drop"}, 32'(o_done), 32'd0);
      check({tag, ".idle_busy"}, 32'(o_busy), 32'd0);
      check({tag, ".rem_hold"}, 32'(o_remaining), 32'(exp_rem));
   endtask

   initial begin
      reset_n          = 1'b0;
      i_trigger_return = 1'b0;
      i_balance        = 31'd0;
      i_coin_ready     = 1'b0;
      #1;
      check("rst.valid", 32'(o_coin_valid), 32'd0);
      check("rst.coin", 32'(o_return_coin), 32'd0);
      check("rst.busy", 32'(o_busy), 32'd0);
      check("rst.done", 32'(o_done), 32'd0);
      check("rst.rem", 32'(o_remaining), 32'd0);
      check("rst.count", 32'(o_coin_count), 32'd0);
      #11;
      reset_n = 1'b1;
      step();

      // 1600 -> 1000, 500, 100.
      refund("b1600", 31'd1600, 3, {15'd0, 3'b001, 3'b010, 3'b100}, 31'd0, 1'b0);
      // 2700 -> 1000, 1000, 500, 100, 100.
      refund("b2700", 31'd2700, 5, {9'd0, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100}, 31'd0, 1'b0);
      // 250 -> 100, 100, residue 50.
      refund("b250", 31'd250, 2, {18'd0, 3'b001, 3'b001}, 31'd50, 1'b0);
      // Zero balance: done at T+2, no coin.
      refund("b0", 31'd0, 0, 24'd0, 31'd0, 1'b0);
      // Trigger with 9999 during an active 1600 refund is ignored.
      refund("ign", 31'd1600, 3, {15'd0, 3'b001, 3'b010, 3'b100}, 31'd0, 1'b1);

      // Backpressure: 500 coin held for three cycles with ready low.
      i_coin_ready     = 1'b0;
      i_balance        = 31'd500;
      i_trigger_return = 1'b1;
      step();
      i_trigger_return = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("bp.valid%0d", k), 32'(o_coin_valid), 32'd1);
         check($sformatf("bp.coin%0d", k), 32'(o_return_coin), 32'd2);
         check($sformatf("bp.rem%0d", k), 32'(o_remaining), 32'd500);
      end
      i_coin_ready = 1'b1;
      step();
      i_coin_ready = 1'b0;
      check("bp.sel_valid", 32'(o_coin_valid), 32'd0);
      check("bp.rem_after", 32'(o_remaining), 32'd0);
      check("bp.count", 32'(o_coin_count), 32'd1);
      step();
      check("bp.done", 32'(o_done), 32'd1);
      check("bp.count_done", 32'(o_coin_count), 32'd1);
      step();
      check("bp.idle", 32'(o_busy), 32'd0);

      // Asynchronous reset during an offer of the 1000 coin.
      i_balance        = 31'd1600;
      i_trigger_return = 1'b1;
      step();
      i_trigger_return = 1'b0;
      step();
      check("ar.valid_pre", 32'(o_coin_valid), 32'd1);
      check("ar.coin_pre", 32'(o_return_coin), 32'd4);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar.valid", 32'(o_coin_valid), 32'd0);
      check("ar.coin", 32'(o_return_coin), 32'd0);
      check("ar.busy", 32'(o_busy), 32'd0);
      check("ar.rem", 32'(o_remaining), 32'd0);
      step();
      reset_n = 1'b1;
      step();
      check("ar.idle_busy", 32'(o_busy), 32'd0);
      check("ar.idle_valid", 32'(o_coin_valid), 32'd0);
      check("ar.idle_rem", 32'(o_remaining), 32'd0);
      check("ar.idle_count", 32'(o_coin_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
